// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge: Wishbone B4 classic slave feeding the hyperbus FIFO user port.
// Each WB cycle becomes one rrq/wrq pulse. The bridge then waits for tx_done/rx_valid and
// acks the master. If no response arrives within TIMEOUT cycles it raises err and drains
// the late response. Every output is registered.
// Timing: the request pulse is visible in the first WAIT cycle (timer = 0). A response
// sampled while the timer is at most TIMEOUT-1 is acked in the following (RESP) cycle.
// Without a response, err is visible exactly TIMEOUT cycles after the request pulse.
module hyperbus_wb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADR_SHIFT  = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    rrq,
  output logic                    wrq,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   tx_dat_o,
  output logic [DATA_WIDTH/8-1:0] tx_mask_o,
  input  logic                    tx_done,
  input  logic [DATA_WIDTH-1:0]   rx_dat_i,
  input  logic                    rx_valid
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  // Last timer value at which a response is still accepted.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_R = 3'd1,
    WAIT_W = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [7:0]            timer, timer_next;
  logic                  req_we, req_we_next;
  logic                  rrq_next, wrq_next, ack_next, err_next;
  logic [DATA_WIDTH-1:0] dat_next, txd_next;
  logic [ADDR_WIDTH-1:0] adr_next;
  logic [SEL_WIDTH-1:0]  mask_next;
  logic                  wb_req;

  assign wb_req = wb_cyc_i && wb_stb_i;

  // Next-state and next-output logic; outputs are pulses unless explicitly held.
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    req_we_next = req_we;
    rrq_next    = 1'b0;
    wrq_next    = 1'b0;
    ack_next    = 1'b0;
    err_next    = 1'b0;
    dat_next    = wb_dat_o;
    adr_next    = adr_o;
    txd_next    = tx_dat_o;
    mask_next   = tx_mask_o;
    case (state)
      IDLE: begin
        if (wb_req) begin
          adr_next    = wb_adr_i >> ADR_SHIFT;
          txd_next    = wb_dat_i;
          mask_next   = ~wb_sel_i;
          rrq_next    = !wb_we_i;
          wrq_next    = wb_we_i;
          req_we_next = wb_we_i;
          timer_next  = 8'd0;
          state_next  = wb_we_i ? WAIT_W : WAIT_R;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_R: begin
        if (rx_valid) begin
          dat_next   = rx_dat_i;
          ack_next   = wb_req;
          state_next = RESP;
        end else if (timer == TIMER_LAST) begin
          err_next   = 1'b1;
          state_next = DRAIN;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      WAIT_W: begin
        if (tx_done) begin
          ack_next   = wb_req;
          state_next = RESP;
        end else if (timer == TIMER_LAST) begin
          err_next   = 1'b1;
          state_next = DRAIN;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      DRAIN: begin
        // Only the response matching the timed-out request releases the bridge.
        if ((req_we && tx_done) || (!req_we && rx_valid)) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, timer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= 8'd0;
      req_we    <= 1'b0;
      rrq       <= 1'b0;
      wrq       <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      adr_o     <= '0;
      tx_dat_o  <= '0;
      tx_mask_o <= '0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      req_we    <= req_we_next;
      rrq       <= rrq_next;
      wrq       <= wrq_next;
      wb_ack_o  <= ack_next;
      wb_err_o  <= err_next;
      wb_dat_o  <= dat_next;
      adr_o     <= adr_next;
      tx_dat_o  <= txd_next;
      tx_mask_o <= mask_next;
    end
  end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Testbench for hyperbus_wb_bridge: a table of WB transactions with expected results, then
// randomized transactions whose expectations come from a transaction-level model, plus
// hand-written reset and drain sequences.
module tb_hyperbus_wb_bridge;

  localparam int T = 20;

  logic        clk;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, adr_o, tx_dat_o, rx_dat_i;
  logic [3:0]  wb_sel_i, tx_mask_o;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic        rrq, wrq, tx_done, rx_valid;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_rd;

  hyperbus_wb_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ADR_SHIFT(1), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .rrq(rrq), .wrq(wrq), .adr_o(adr_o), .tx_dat_o(tx_dat_o),
    .tx_mask_o(tx_mask_o), .tx_done(tx_done), .rx_dat_i(rx_dat_i), .rx_valid(rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: d = response delay in cycles after the request pulse,
  // drop = cycle at which the master abandons the cycle (-1 = never),
  // keep = master leaves cyc/stb high after ack/err, unsol = stray responses in IDLE.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          d;
    logic [31:0] rdata;
    int          drop;
    logic        keep;
    logic        unsol;
    logic [31:0] exp_adr;
    logic [3:0]  exp_mask;
    int          exp_ack_k;
    int          exp_err_k;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a response within T-1 cycles is acked one cycle later unless
  // the master has already dropped the cycle; otherwise err appears T cycles after request.
  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int d, input logic [31:0] rdata,
                              input int drop, input logic keep, input logic unsol);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.d = d; v.rdata = rdata;
    v.drop = drop; v.keep = keep; v.unsol = unsol;
    v.exp_adr   = adr / 32'd2;
    v.exp_mask  = 4'hF ^ sel;
    v.exp_ack_k = (d < T && !(drop >= 0 && drop <= d)) ? d + 1 : -1;
    v.exp_err_k = (d >= T) ? T : -1;
    return v;
  endfunction

  // Must be called at #1 after a posedge with the bridge idle in that cycle.
  task automatic run_txn(input vec_t v);
    int end_k;
    wb_we_i = v.we; wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    end_k = (v.d < T) ? v.d + 2 : v.d + 1;
    for (int k = 0; k <= end_k; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("rrq", 64'(rrq), 64'(k == 0 && !v.we));
      chk("wrq", 64'(wrq), 64'(k == 0 && v.we));
      if (k == 0) begin
        chk("adr_o", 64'(adr_o), 64'(v.exp_adr));
        chk("tx_dat_o", 64'(tx_dat_o), 64'(v.dat));
        chk("tx_mask_o", 64'(tx_mask_o), 64'(v.exp_mask));
      end
      chk("ack", 64'(wb_ack_o), 64'(k == v.exp_ack_k));
      chk("err", 64'(wb_err_o), 64'(k == v.exp_err_k));
      if (k == v.exp_ack_k && !v.we) chk("rd_data", 64'(wb_dat_o), 64'(v.rdata));
      rx_valid = (!v.we && k == v.d);
      tx_done  = (v.we && k == v.d);
      rx_dat_i = (k == v.d) ? v.rdata : $urandom;
      if (k == v.drop) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if ((k == v.exp_ack_k || k == v.exp_err_k) && !v.keep) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (k == end_k && v.unsol) begin
        rx_valid = 1'b1; tx_done = 1'b1;
      end
    end
    if (!v.we && v.d < T) last_rd = v.rdata;
    chk("dat_hold", 64'(wb_dat_o), 64'(last_rd));
  endtask

  // Protocol exclusivity checks on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rrq_wrq_excl", 64'(rrq && wrq), 64'(0));
      chk("ack_err_excl", 64'(wb_ack_o && wb_err_o), 64'(0));
    end
  end

  vec_t tbl[$];

  initial begin
    vec_t v;
    int r, d, drop;
    rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_dat_i = '0;
    last_rd = '0;

    // Hand-entered table: example write, example read, timeout boundaries, drain stall,
    // abort, back-to-back writes.
    tbl.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 3, 32'h0, -1, 1'b0, 1'b0,
                    32'h80, 4'b1100, 4, -1});
    tbl.push_back('{1'b0, 32'h40, 32'h0, 4'hF, 5, 32'h12345678, -1, 1'b0, 1'b0,
                    32'h20, 4'b0000, 6, -1});
    tbl.push_back('{1'b0, 32'h44, 32'h0, 4'hF, T - 1, 32'hCAFE0001, -1, 1'b0, 1'b0,
                    32'h22, 4'b0000, T, -1});
    tbl.push_back('{1'b0, 32'h48, 32'h0, 4'hF, T + 4, 32'hBAD0BAD0, -1, 1'b1, 1'b0,
                    32'h24, 4'b0000, -1, T});
    tbl.push_back('{1'b0, 32'h200, 32'h0, 4'hF, 2, 32'h0BB0_1234, -1, 1'b0, 1'b0,
                    32'h100, 4'b0000, 3, -1});
    tbl.push_back('{1'b1, 32'h300, 32'h11112222, 4'b1010, 3, 32'h0, 1, 1'b0, 1'b0,
                    32'h180, 4'b0101, -1, -1});
    tbl.push_back('{1'b1, 32'h304, 32'h33334444, 4'b1111, 1, 32'h0, -1, 1'b1, 1'b0,
                    32'h182, 4'b0000, 2, -1});
    tbl.push_back('{1'b1, 32'h308, 32'h55556666, 4'b0001, 0, 32'h0, -1, 1'b0, 1'b1,
                    32'h184, 4'b1110, 1, -1});
    tbl.push_back('{1'b0, 32'h50, 32'h0, 4'hF, T, 32'hFFFF0000, -1, 1'b0, 1'b0,
                    32'h28, 4'b0000, -1, T});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(wb_ack_o), 64'(0));
    chk("rst_err", 64'(wb_err_o), 64'(0));
    chk("rst_rrq", 64'(rrq), 64'(0));
    chk("rst_wrq", 64'(wrq), 64'(0));
    chk("rst_adr", 64'(adr_o), 64'(0));
    chk("rst_dat", 64'(wb_dat_o), 64'(0));
    chk("rst_mask", 64'(tx_mask_o), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i]);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       d = $urandom_range(0, 6);
      else if (r == 7) d = T - 1 + $urandom_range(0, 1);
      else             d = T + $urandom_range(0, 4);
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, d) : -1;
      v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), d,
             $urandom, drop, 1'b0, 1'($urandom_range(0, 1)));
      run_txn(v);
    end

    // Reset during WAIT_R aborts silently; a later rx_valid is ignored.
    rx_valid = 1'b0; tx_done = 1'b0;
    wb_we_i = 1'b0; wb_adr_i = 32'h600; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_seq_rrq", 64'(rrq), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rrq", 64'(rrq), 64'(0));
    chk("midrst_ack", 64'(wb_ack_o), 64'(0));
    chk("midrst_err", 64'(wb_err_o), 64'(0));
    chk("midrst_adr", 64'(adr_o), 64'(0));
    chk("midrst_dat", 64'(wb_dat_o), 64'(0));
    chk("midrst_txd", 64'(tx_dat_o), 64'(0));
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rx_valid = 1'b1; rx_dat_i = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    last_rd = '0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_ack", 64'(wb_ack_o), 64'(0));
      chk("post_rst_dat", 64'(wb_dat_o), 64'(0));
      @(posedge clk); #1;
    end
    run_txn(mk(1'b1, 32'h700, 32'h01020304, 4'hC, 2, 32'h0, -1, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
